param_instr_mem: RTL

- Parametrised successor to the single-width instruction memory.
- Holds program words written by the debug/loader unit, then serves registered instruction fetches to the IF stage.
- Adds a load FSM with an auto-incrementing write pointer, fill tracking, configurable byte or word addressing, out-of-range and misalignment detection, and a sticky halt.
- Sits between the UART/debug loader and the IF stage; the IF stage stalls on o_halt.

---
 rtl/param_instr_mem.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/param_instr_mem.sv
// Parametrised instruction memory for the IF stage.
// A loader fills it in LOAD state through an auto-incrementing write pointer.
// In RUN state it serves registered fetches. A halt opcode or an illegal fetch
// (out of range or misaligned) sets a sticky halt that freezes the fetch outputs.
module param_instr_mem #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = 64,
    parameter int unsigned       ADDR_W      = 32,
    parameter bit                BYTE_ADDR   = 1'b1,
    parameter logic [5:0]        HALT_OPCODE = 6'b111111,
    parameter logic [DATA_W-1:0] NOP_WORD    = '0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_load_en,
    input  logic                     i_load_valid,
    input  logic [DATA_W-1:0]        i_load_data,
    input  logic                     i_load_done,
    input  logic [ADDR_W-1:0]        i_pc,
    input  logic                     i_rd_en,
    output logic [DATA_W-1:0]        o_instr,
    output logic                     o_halt,
    output logic                     o_addr_err,
    output logic                     o_load_full,
    output logic [$clog2(DEPTH):0]   o_load_count,
    output logic                     o_running
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Common width so the range check never truncates either operand
    localparam int unsigned CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
    localparam logic [DATA_W-1:0] HALT_WORD = {HALT_OPCODE, {(DATA_W-6){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } state_e;

    state_e state, state_next;

    logic [CNT_W-1:0]  count, count_next;
    logic [DATA_W-1:0] instr, instr_next;
    logic              halt, halt_next;
    logic              addr_err, addr_err_next;
    logic              mem_we;
    logic              full;

    // Program storage; deliberately not cleared by reset
    logic [DATA_W-1:0] mem [DEPTH];

    // Fetch decode
    logic [ADDR_W-1:0] word_idx;
    logic [CMP_W-1:0]  idx_cmp;
    logic [CMP_W-1:0]  count_cmp;
    logic              misaligned;
    logic              out_of_range;
    logic              fetch_ok;
    logic [DATA_W-1:0] rd_word;
    logic              rd_halt;

    assign full = (count == CNT_W'(DEPTH));

    // Translate the PC into a word index and classify the fetch
    always_comb begin
        word_idx     = BYTE_ADDR ? (i_pc >> 2) : i_pc;
        idx_cmp      = CMP_W'(word_idx);
        count_cmp    = CMP_W'(count);
        misaligned   = BYTE_ADDR && (i_pc[1:0] != 2'b00);
        // idx >= count also covers an empty program
        out_of_range = (idx_cmp >= count_cmp);
        fetch_ok     = !misaligned && !out_of_range;
        // Only meaningful when fetch_ok, which guarantees idx < DEPTH
        rd_word      = mem[idx_cmp[IDX_W-1:0]];
        rd_halt      = (rd_word[DATA_W-1 -: 6] == HALT_OPCODE);
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; load request outranks fetch in RUN
    always_comb begin
        state_next = state;
        unique case (state)
            StIdle: begin
                if (i_load_en) begin
                    state_next = StLoad;
                end
            end
            StLoad: begin
                // A re-request while loading is ignored; only done matters
                if (i_load_done) begin
                    state_next = StRun;
                end
            end
            StRun: begin
                if (i_load_en) begin
                    state_next = StLoad;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    // Datapath next-state: write pointer, fetch result and flags
    always_comb begin
        count_next    = count;
        instr_next    = instr;
        halt_next     = halt;
        addr_err_next = addr_err;
        mem_we        = 1'b0;
        unique case (state)
            StIdle: begin
                if (i_load_en) begin
                    count_next = '0;
                end
            end
            StLoad: begin
                instr_next = NOP_WORD;
                // Words past capacity are dropped; the write happens before any
                // same-cycle transition to RUN
                if (i_load_valid && !full) begin
                    mem_we     = 1'b1;
                    count_next = count + CNT_W'(1);
                end
                if (i_load_done) begin
                    halt_next     = 1'b0;
                    addr_err_next = 1'b0;
                end
            end
            StRun: begin
                if (i_load_en) begin
                    count_next    = '0;
                    instr_next    = NOP_WORD;
                    halt_next     = 1'b0;
                    addr_err_next = 1'b0;
                end else if (i_rd_en && !halt) begin
                    // Once halted, outputs freeze until reload or reset
                    addr_err_next = !fetch_ok;
                    if (fetch_ok) begin
                        instr_next = rd_word;
                        halt_next  = rd_halt;
                    end else begin
                        instr_next = HALT_WORD;
                        halt_next  = 1'b1;
                    end
                end
            end
            default: begin
                count_next = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count    <= '0;
            instr    <= NOP_WORD;
            halt     <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            count    <= count_next;
            instr    <= instr_next;
            halt     <= halt_next;
            addr_err <= addr_err_next;
        end
    end

    // Program write port at the current write pointer
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[count[IDX_W-1:0]] <= i_load_data;
        end
    end

    // FSM/status outputs
    always_comb begin
        o_running    = (state == StRun);
        o_load_full  = full;
        o_load_count = count;
        o_instr      = instr;
        o_halt       = halt;
        o_addr_err   = addr_err;
    end

`ifndef SYNTHESIS
    // Write pointer never exceeds capacity
    assert property (@(posedge i_clk) disable iff (i_reset) count <= CNT_W'(DEPTH));
    // Outside RUN the fetch outputs sit at their idle values
    assert property (@(posedge i_clk) disable iff (i_reset)
        (state != StRun) |-> (instr == NOP_WORD && !halt && !addr_err));
`endif

endmodule
